mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage pipeline. Consumes the EX-stage results (op, destination register, branch condition, ALU result, effective address) and holds them in the EX/MEM pipeline register.
- Performs word stores and loads against an internal data memory.
- Redirects fetch on a taken BEQ or a JMP and squashes the wrong-path instruction.
- Presents registered writeback results to the WB stage and counts retired instructions.

Parameters:
- AW, 8, data-memory word-address width (depth = 2^AW 32-bit words).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- valid_ex  in  1  EX-stage fields hold a real instruction
- op_ex  in  6  opcode: 000000 ADD, 000001 SUB, 000010 AND, 000011 OR, 000100 XOR, 000101 SLT, 010000 SW, 010001 LW, 100000 BEQ, 100001 JMP
- ri_ex  in  5  destination register index
- ife_ex  in  1  BEQ condition true
- alu_ex  in  32  ALU result; store data for SW
- addr_ex  in  32  byte address for SW/LW, branch/jump target for BEQ/JMP
- pc_sel_mem  out  1  redirect fetch this cycle
- target_mem  out  32  redirect target
- we_wb  out  1  register-file write enable
- ri_wb  out  5  register-file write index
- wdata_wb  out  32  register-file write data
- mem_err  out  1  sticky out-of-range access flag
- retired  out  32  count of valid instructions leaving MEM

Behaviour:
- Reset (async, immediate): all EX/MEM and MEM/WB registers = 0, including valid bits. pc_sel_mem=0, target_mem=0, we_wb=0, ri_wb=0, wdata_wb=0, mem_err=0, retired=0. Memory contents are not reset.
- Edge E1 (EX/MEM latch): op_m, ri_m, ife_m, alu_m, addr_m <= EX inputs. v_m <= valid_ex & ~pc_sel_mem.
  - The squash applies to the instruction behind the branch; a taken branch kills the instruction entering MEM at the same edge.
- Redirect (combinational from the EX/MEM register, during the cycle after E1):
  - pc_sel_mem = v_m & ((op_m==BEQ & ife_m) | op_m==JMP).
  - target_mem = addr_m. Driven continuously; meaningful only while pc_sel_mem=1.
- Address decode:
  - Word index = addr_m[AW+1:2]; addr_m[1:0] ignored.
  - in_range = (addr_m[31:AW+2]==0).
- Store: on the edge after E1 (E2), if v_m & op_m==SW & in_range: mem[index] <= alu_m.
- Edge E2 (MEM/WB latch):
  - ri_wb <= ri_m.
  - wdata_wb <= (op_m==LW) ? (in_range ? mem[index] : 0) : alu_m.
  - we_wb <= v_m & (op_m in ALU group or LW) & (ri_m!=0). Register 0 is never written.
  - Resulting latency: EX presentation in cycle N; writeback visible in cycle N+2.
- SW followed by LW to the same address on consecutive cycles: the LW reads the new value. The write lands at the SW's E2 and the LW reads at its own E2, one cycle later. No bypass is needed.
- mem_err <= 1 at E2 when v_m & (op_m==SW or LW) & ~in_range. Stays set until reset.
- retired increments at E2 when v_m=1, for all opcodes including undefined ones. Wraps 0xFFFFFFFF -> 0.
- Undefined opcode with v_m=1: no store, no redirect, we_wb=0, counted as retired.
- valid_ex=0: bubble; nothing is written and retired is unchanged.
- Reset mid-operation: in-flight instructions are discarded, and a store whose E2 coincides with rst is not performed.

Test Plan:
- ALU op: valid_ex=1, op=000000, ri=5, alu=0x0000_0007 -> two cycles later we_wb=1, ri_wb=5, wdata_wb=7; retired=1.
- Store/load: SW addr=0x10, alu=0xDEADBEEF; next cycle LW addr=0x10, ri=3 -> LW writeback we_wb=1, ri_wb=3, wdata_wb=0xDEADBEEF; mem_err=0.
- Taken BEQ: BEQ ife=1, addr=0x40, then ADD ri=4 next cycle -> pc_sel_mem=1, target=0x40 for one cycle; the ADD never writes (we_wb stays 0); retired counts only the BEQ.
- Not-taken BEQ (ife=0) and JMP addr=0x80 -> BEQ: pc_sel_mem=0. JMP: pc_sel_mem=1, target_mem=0x80. Neither asserts we_wb.
- Out-of-range: LW addr=0x0001_0000 (AW=8), ri=2 -> wdata_wb=0, we_wb=1, mem_err=1 and it remains 1. A following in-range SW still writes memory.
- Reset/edge cases:
  - ADD with ri=0 -> we_wb=0.
  - Undefined op 111111 -> retired increments, no write.
  - rst pulse mid-stream -> all outputs 0 immediately.
  - Force retired to 0xFFFFFFFF, then retire 1 instruction -> retired=0.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: EX/MEM register, data memory, redirect, MEM/WB register
module mem_stage #(
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_ex,
    input  logic [5:0]  op_ex,
    input  logic [4:0]  ri_ex,
    input  logic        ife_ex,
    input  logic [31:0] alu_ex,
    input  logic [31:0] addr_ex,
    output logic        pc_sel_mem,
    output logic [31:0] target_mem,
    output logic        we_wb,
    output logic [4:0]  ri_wb,
    output logic [31:0] wdata_wb,
    output logic        mem_err,
    output logic [31:0] retired
);

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR  = 6'b000011;
    localparam logic [5:0] OP_XOR = 6'b000100;
    localparam logic [5:0] OP_SLT = 6'b000101;
    localparam logic [5:0] OP_SW  = 6'b010000;
    localparam logic [5:0] OP_LW  = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_JMP = 6'b100001;

    logic        v_m;
    logic [5:0]  op_m;
    logic [4:0]  ri_m;
    logic        ife_m;
    logic [31:0] alu_m;
    logic [31:0] addr_m;

    logic [31:0]   mem [2**AW];
    logic [AW-1:0] index;
    logic          in_range;
    logic          is_alu;
    logic          is_sw;
    logic          is_lw;
    logic          store_en;
    logic [31:0]   rd_data;

    // The instruction entering MEM behind a taken redirect is dropped here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_m    <= 1'b0;
            op_m   <= '0;
            ri_m   <= '0;
            ife_m  <= 1'b0;
            alu_m  <= '0;
            addr_m <= '0;
        end else begin
            v_m    <= valid_ex & ~pc_sel_mem;
            op_m   <= op_ex;
            ri_m   <= ri_ex;
            ife_m  <= ife_ex;
            alu_m  <= alu_ex;
            addr_m <= addr_ex;
        end
    end

    always_comb begin
        is_alu = 1'b0;
        case (op_m)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: is_alu = 1'b1;
            default:                                       is_alu = 1'b0;
        endcase
    end

    assign is_sw    = (op_m == OP_SW);
    assign is_lw    = (op_m == OP_LW);
    assign index    = addr_m[AW+1:2];
    assign in_range = (addr_m[31:AW+2] == '0);
    assign store_en = v_m & is_sw & in_range;

    assign pc_sel_mem = v_m & (((op_m == OP_BEQ) & ife_m) | (op_m == OP_JMP));
    assign target_mem = addr_m;

    // v_m is already cleared asynchronously; the rst term keeps a store off a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && store_en) begin
            mem[index] <= alu_m;
        end
    end

    assign rd_data = in_range ? mem[index] : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_wb    <= 1'b0;
            ri_wb    <= '0;
            wdata_wb <= '0;
            mem_err  <= 1'b0;
            retired  <= '0;
        end else begin
            ri_wb    <= ri_m;
            wdata_wb <= is_lw ? rd_data : alu_m;
            we_wb    <= v_m & (is_alu | is_lw) & (ri_m != 5'd0);
            if (v_m & (is_sw | is_lw) & ~in_range) begin
                mem_err <= 1'b1;
            end
            if (v_m) begin
                retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage against a program-order reference model
module tb_mem_stage;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR  = 6'b000011;
    localparam logic [5:0] OP_XOR = 6'b000100;
    localparam logic [5:0] OP_SLT = 6'b000101;
    localparam logic [5:0] OP_SW  = 6'b010000;
    localparam logic [5:0] OP_LW  = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_JMP = 6'b100001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_ex = 1'b0;
    logic [5:0]  op_ex = '0;
    logic [4:0]  ri_ex = '0;
    logic        ife_ex = 1'b0;
    logic [31:0] alu_ex = '0;
    logic [31:0] addr_ex = '0;
    logic        pc_sel_mem;
    logic [31:0] target_mem;
    logic        we_wb;
    logic [4:0]  ri_wb;
    logic [31:0] wdata_wb;
    logic        mem_err;
    logic [31:0] retired;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .valid_ex   (valid_ex),
        .op_ex      (op_ex),
        .ri_ex      (ri_ex),
        .ife_ex     (ife_ex),
        .alu_ex     (alu_ex),
        .addr_ex    (addr_ex),
        .pc_sel_mem (pc_sel_mem),
        .target_mem (target_mem),
        .we_wb      (we_wb),
        .ri_wb      (ri_wb),
        .wdata_wb   (wdata_wb),
        .mem_err    (mem_err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: architectural memory, retire count, error flag, squash shadow.
    logic [31:0] m_mem [256];
    logic [31:0] m_ret = '0;
    logic        m_err = 1'b0;
    logic        prev_taken = 1'b0;

    logic [4:0]  exp_ri [$];
    logic [31:0] exp_data [$];
    logic [31:0] exp_tgt [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [5:0] op, input logic [4:0] ri,
                         input logic ife, input logic [31:0] alu, input logic [31:0] addr);
        logic live;
        logic inr;
        logic [31:0] d;
        @(negedge clk);
        valid_ex = v;
        op_ex    = op;
        ri_ex    = ri;
        ife_ex   = ife;
        alu_ex   = alu;
        addr_ex  = addr;
        live = v && !prev_taken;
        prev_taken = live && ((op == OP_BEQ && ife) || op == OP_JMP);
        if (live) begin
            m_ret = m_ret + 32'd1;
            inr = (addr[31:10] == 22'd0);
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
                    if (ri != 5'd0) begin
                        exp_ri.push_back(ri);
                        exp_data.push_back(alu);
                    end
                end
                OP_LW: begin
                    if (!inr) m_err = 1'b1;
                    d = inr ? m_mem[addr[9:2]] : 32'h0;
                    if (ri != 5'd0) begin
                        exp_ri.push_back(ri);
                        exp_data.push_back(d);
                    end
                end
                OP_SW: begin
                    if (inr) m_mem[addr[9:2]] = alu;
                    else     m_err = 1'b1;
                end
                OP_BEQ, OP_JMP: begin
                    if (prev_taken) exp_tgt.push_back(addr);
                end
                default: ;
            endcase
        end
    endtask

    task automatic bubble();
        issue(1'b0, OP_ADD, 5'd0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drain_check(input string tag);
        repeat (3) bubble();
        chk({tag, "_retired"}, retired, m_ret);
        chk({tag, "_mem_err"}, {31'd0, mem_err}, {31'd0, m_err});
        chk({tag, "_wb_pending"}, exp_ri.size(), 0);
        chk({tag, "_tgt_pending"}, exp_tgt.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc_sel"}, {31'd0, pc_sel_mem}, 32'd0);
        chk({tag, "_target"}, target_mem, 32'd0);
        chk({tag, "_we_wb"}, {31'd0, we_wb}, 32'd0);
        chk({tag, "_ri_wb"}, {27'd0, ri_wb}, 32'd0);
        chk({tag, "_wdata"}, wdata_wb, 32'd0);
        chk({tag, "_mem_err"}, {31'd0, mem_err}, 32'd0);
        chk({tag, "_retired"}, retired, 32'd0);
    endtask

    // Monitor: every writeback and every redirect must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (we_wb) begin
                if (exp_ri.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL wb_unexpected: got ri=%0d data=%h expected no write", ri_wb, wdata_wb);
                end else begin
                    chk("wb_ri", {27'd0, ri_wb}, {27'd0, exp_ri.pop_front()});
                    chk("wb_data", wdata_wb, exp_data.pop_front());
                end
            end
            if (pc_sel_mem) begin
                if (exp_tgt.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL redirect_unexpected: got target=%h expected no redirect", target_mem);
                end else begin
                    chk("redirect_target", target_mem, exp_tgt.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [12];
        logic [31:0] a;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
                OP_SW, OP_LW, OP_BEQ, OP_JMP, 6'b111111, 6'b000111};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        issue(1'b1, OP_ADD, 5'd5, 1'b0, 32'h7, 32'h0);
        drain_check("alu_add");
        chk("alu_add_count", retired, 32'd1);

        for (int i = 0; i < 256; i++) begin
            issue(1'b1, OP_SW, 5'd0, 1'b0, $urandom, 32'(i * 4));
        end
        drain_check("fill");

        issue(1'b1, OP_SW, 5'd0, 1'b0, 32'hDEADBEEF, 32'h10);
        issue(1'b1, OP_LW, 5'd3, 1'b0, 32'h0, 32'h10);
        drain_check("sw_lw");

        issue(1'b1, OP_BEQ, 5'd0, 1'b1, 32'h0, 32'h40);
        issue(1'b1, OP_ADD, 5'd4, 1'b0, 32'h1234, 32'h0);
        drain_check("beq_taken");

        issue(1'b1, OP_BEQ, 5'd0, 1'b0, 32'h0, 32'h60);
        issue(1'b1, OP_JMP, 5'd7, 1'b0, 32'h55, 32'h80);
        issue(1'b1, OP_LW, 5'd8, 1'b0, 32'h0, 32'h10);
        drain_check("beq_nt_jmp");

        issue(1'b1, OP_ADD, 5'd0, 1'b0, 32'h99, 32'h0);
        issue(1'b1, 6'b111111, 5'd9, 1'b1, 32'h77, 32'h40);
        drain_check("r0_undef");

        issue(1'b1, OP_LW, 5'd2, 1'b0, 32'h0, 32'h0001_0000);
        drain_check("oor_lw");
        issue(1'b1, OP_SW, 5'd0, 1'b0, 32'hCAFEF00D, 32'h32);
        issue(1'b1, OP_LW, 5'd6, 1'b0, 32'h0, 32'h30);
        drain_check("oor_then_sw");

        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0000_0400) : {22'd0, 10'($urandom)};
            issue($urandom_range(0, 4) != 0, ops[$urandom_range(0, 11)], 5'($urandom),
                  1'($urandom), $urandom, a);
        end
        drain_check("random");

        // A store whose E2 lands on a reset edge must not reach memory.
        @(negedge clk);
        valid_ex = 1'b1;
        op_ex    = OP_SW;
        ri_ex    = 5'd0;
        alu_ex   = ~m_mem[8];
        addr_ex  = 32'h20;
        @(negedge clk);
        rst = 1'b1;
        valid_ex = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        exp_ri.delete();
        exp_data.delete();
        exp_tgt.delete();
        m_ret = '0;
        m_err = 1'b0;
        prev_taken = 1'b0;
        issue(1'b1, OP_LW, 5'd9, 1'b0, 32'h0, 32'h20);
        drain_check("post_reset");

        @(negedge clk);
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        m_ret = 32'hFFFF_FFFF;
        chk("wrap_preload", retired, 32'hFFFF_FFFF);
        issue(1'b1, OP_XOR, 5'd11, 1'b0, 32'h5A5A, 32'h0);
        drain_check("wrap");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
